// File: rtl/counter_csr_access.sv
// CSR-side access controller for a bank of 64-bit event counters.
// Serves 32-bit low/high reads and writes with a per-counter high-half snapshot, plus an increment inhibit mask.
module counter_csr_access #(
   parameter int NumCounters = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_i,
   output logic                        gnt_o,
   input  logic                        we_i,
   input  logic [6:0]                  addr_i,
   input  logic [31:0]                 wdata_i,
   output logic                        rvalid_o,
   input  logic                        rready_i,
   output logic [31:0]                 rdata_o,
   output logic                        err_o,
   input  logic [NumCounters-1:0]      event_i,
   output logic [NumCounters-1:0]      counter_inc_o,
   output logic [NumCounters-1:0]      counter_we_o,
   output logic [NumCounters-1:0]      counterh_we_o,
   output logic [31:0]                 counter_wdata_o,
   input  logic [NumCounters*64-1:0]   counter_val_i
);

   localparam logic       ST_IDLE     = 1'b0;
   localparam logic       ST_RESP     = 1'b1;
   localparam logic [6:0] InhibitAddr = 7'h7F;

   logic                   r_state;
   logic [31:0]            r_rdata;
   logic                   r_err;
   logic [NumCounters-1:0] r_we_strb;
   logic [NumCounters-1:0] r_weh_strb;
   logic [31:0]            r_wdata;
   logic [NumCounters-1:0] r_inhibit;
   logic [31:0]            r_snap_hi [NumCounters];

   logic                   w_accept;
   logic [5:0]             w_idx;
   logic                   w_in_range;
   logic                   w_is_lo;
   logic                   w_is_hi;
   logic                   w_is_inh;
   logic                   w_err;
   logic [NumCounters-1:0] w_sel;
   logic [31:0]            w_lo_val;
   logic [31:0]            w_hi_val;
   logic [31:0]            w_snap_val;
   logic [31:0]            w_rdata_nxt;

   assign gnt_o      = (r_state == ST_IDLE);
   assign w_accept   = req_i && gnt_o;
   assign w_idx      = addr_i[6:1];
   assign w_in_range = (w_idx < 6'(NumCounters));
   assign w_is_lo    = w_in_range && !addr_i[0];
   assign w_is_hi    = w_in_range && addr_i[0];
   assign w_is_inh   = (addr_i == InhibitAddr);
   assign w_err      = !(w_is_lo || w_is_hi || w_is_inh);

   // Counter select and per-counter value mux for the addressed counter.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_sel      = '0;
      w_lo_val   = '0;
      w_hi_val   = '0;
      w_snap_val = '0;
      for (int k = 0; k < NumCounters; k++) begin
         if (w_idx == 6'(k)) begin
            w_sel[k]   = 1'b1;
            w_lo_val   = counter_val_i[k*64 +: 32];
            w_hi_val   = counter_val_i[k*64+32 +: 32];
            w_snap_val = r_snap_hi[k];
         end
      end
   end

   always_comb begin
      w_rdata_nxt = '0;
      if (!we_i) begin
         if (w_is_lo)       w_rdata_nxt = w_lo_val;
         else if (w_is_hi)  w_rdata_nxt = w_snap_val;
         else if (w_is_inh) w_rdata_nxt = 32'(r_inhibit);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_we_strb  <= '0;
         r_weh_strb <= '0;
         r_wdata    <= '0;
         r_inhibit  <= '0;
      end else begin
         // Strobes are single-cycle pulses regardless of how long the response stalls.
         r_we_strb  <= '0;
         r_weh_strb <= '0;
         if (w_accept) begin
            r_state <= ST_RESP;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err;
            r_wdata <= wdata_i;
            if (we_i) begin
               r_we_strb  <= w_sel & {NumCounters{w_is_lo}};
               r_weh_strb <= w_sel & {NumCounters{w_is_hi}};
               if (w_is_inh) r_inhibit <= wdata_i[NumCounters-1:0];
            end
         end else if ((r_state == ST_RESP) && rready_i) begin
            r_state <= ST_IDLE;
         end
      end
   end

   // A low-half read captures the matching high half so a later high read is coherent.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the snapshot array is reset because a high read before any low read must return 0.
         for (int k = 0; k < NumCounters; k++) r_snap_hi[k] <= '0;
      end else if (w_accept) begin
         for (int k = 0; k < NumCounters; k++) begin
            if (w_sel[k]) begin
               if (!we_i && w_is_lo)     r_snap_hi[k] <= w_hi_val;
               else if (we_i && w_is_hi) r_snap_hi[k] <= wdata_i;
            end
         end
      end
   end

   assign rvalid_o        = (r_state == ST_RESP);
   assign rdata_o         = r_rdata;
   assign err_o           = r_err;
   assign counter_we_o    = r_we_strb;
   assign counterh_we_o   = r_weh_strb;
   assign counter_wdata_o = r_wdata;
   assign counter_inc_o   = event_i & ~r_inhibit;

endmodule

// File: tb/tb_counter_csr_access.sv
// Testbench for counter_csr_access: directed accesses against a two-counter bank model,
// responses checked by a queue-based monitor.
module tb_counter_csr_access;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        gnt_o;
   logic        we_i;
   logic [6:0]  addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic        rready_i;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [1:0]  event_i;
   logic [1:0]  counter_inc_o;
   logic [1:0]  counter_we_o;
   logic [1:0]  counterh_we_o;
   logic [31:0] counter_wdata_o;
   logic [127:0] counter_val_i;

   int n_checks = 0;
   int n_errors = 0;
   logic [32:0] exp_q [$];
   logic [63:0] cnt [2];

   always #5 clk_i = ~clk_i;

   counter_csr_access #(.NumCounters(2)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_i           (req_i),
      .gnt_o           (gnt_o),
      .we_i            (we_i),
      .addr_i          (addr_i),
      .wdata_i         (wdata_i),
      .rvalid_o        (rvalid_o),
      .rready_i        (rready_i),
      .rdata_o         (rdata_o),
      .err_o           (err_o),
      .event_i         (event_i),
      .counter_inc_o   (counter_inc_o),
      .counter_we_o    (counter_we_o),
      .counterh_we_o   (counterh_we_o),
      .counter_wdata_o (counter_wdata_o),
      .counter_val_i   (counter_val_i)
   );

   // Counter bank model: write beats increment.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (counter_we_o[k])       cnt[k][31:0]  <= counter_wdata_o;
            else if (counterh_we_o[k]) cnt[k][63:32] <= counter_wdata_o;
            else if (counter_inc_o[k]) cnt[k]        <= cnt[k] + 64'd1;
         end
      end
   end
   assign counter_val_i = {cnt[1], cnt[0]};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected response per completed handshake.
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1 && rvalid_o && rready_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got rdata %0h with no expected response", rdata_o);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("resp_rdata", {32'h0, rdata_o}, {32'h0, e[31:0]});
            check("resp_err", {63'h0, err_o}, {63'h0, e[32]});
         end
      end
   end

   // One access: issue, expect grant, check latency/strobes, optionally stall the response.
   task automatic access(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [1:0] exp_we, input logic [1:0] exp_weh,
                         input logic [1:0] ev, input int stall);
      logic [31:0] first;
      int          waited;
      @(posedge clk_i); #1;
      rready_i = (stall == 0);
      event_i  = ev;
      req_i    = 1'b1;
      we_i     = we;
      addr_i   = addr;
      wdata_i  = wd;
      waited   = 0;
      @(negedge clk_i);
      while (!gnt_o && waited < 20) begin
         @(negedge clk_i);
         waited++;
      end
      check("grant", {63'h0, gnt_o}, 64'h1);
      exp_q.push_back({exp_err, exp_rd});
      @(posedge clk_i); #1;
      req_i = 1'b0;
      @(negedge clk_i);
      check("rvalid_latency", {63'h0, rvalid_o}, 64'h1);
      check("strobe_lo_t1", {62'h0, counter_we_o}, {62'h0, exp_we});
      check("strobe_hi_t1", {62'h0, counterh_we_o}, {62'h0, exp_weh});
      if (we) check("counter_wdata", {32'h0, counter_wdata_o}, {32'h0, wd});
      first = rdata_o;
      @(negedge clk_i);
      check("strobe_lo_t2", {62'h0, counter_we_o}, 64'h0);
      check("strobe_hi_t2", {62'h0, counterh_we_o}, 64'h0);
      if (stall > 0) begin
         for (int i = 2; i <= stall; i++) begin
            if (i > 2) @(negedge clk_i);
            check("stall_rvalid", {63'h0, rvalid_o}, 64'h1);
            check("stall_gnt", {63'h0, gnt_o}, 64'h0);
            check("stall_rdata", {32'h0, rdata_o}, {32'h0, first});
         end
         @(posedge clk_i); #1;
         rready_i = 1'b1;
         @(negedge clk_i);
      end
      waited = 0;
      while (rvalid_o && waited < 20) begin
         @(negedge clk_i);
         waited++;
      end
      check("resp_done", {63'h0, rvalid_o}, 64'h0);
   endtask

   initial begin
      rst_ni   = 1'b0;
      req_i    = 1'b0;
      we_i     = 1'b0;
      addr_i   = '0;
      wdata_i  = '0;
      rready_i = 1'b1;
      event_i  = 2'b11;
      #12;
      check("rst_rvalid", {63'h0, rvalid_o}, 64'h0);
      check("rst_rdata", {32'h0, rdata_o}, 64'h0);
      check("rst_err", {63'h0, err_o}, 64'h0);
      check("rst_strobes", {60'h0, counter_we_o, counterh_we_o}, 64'h0);
      check("rst_wdata", {32'h0, counter_wdata_o}, 64'h0);
      check("rst_inc_uninhibited", {62'h0, counter_inc_o}, 64'h3);
      @(negedge clk_i);
      event_i = 2'b00;
      rst_ni  = 1'b1;
      #1;
      check("gnt_after_reset", {63'h0, gnt_o}, 64'h1);

      // Write then read back counter 0 low.
      access(1'b1, 7'd0, 32'h5, 32'h0, 1'b0, 2'b01, 2'b00, 2'b00, 0);
      access(1'b0, 7'd0, 32'h0, 32'h5, 1'b0, 2'b00, 2'b00, 2'b00, 0);

      // Preload counter 1 to 0x0000_0000_FFFF_FFFF, then coherent read while it wraps.
      access(1'b1, 7'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b10, 2'b00, 2'b00, 0);
      access(1'b1, 7'd3, 32'h0, 32'h0, 1'b0, 2'b00, 2'b10, 2'b00, 0);
      access(1'b0, 7'd2, 32'h0, 32'hFFFF_FFFF, 1'b0, 2'b00, 2'b00, 2'b10, 0);
      check("inc_event1", {62'h0, counter_inc_o}, 64'h2);
      access(1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b10, 0);
      // Interleaved access to counter 0 must not disturb counter 1's snapshot.
      access(1'b0, 7'd1, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);

      // Inhibit counter 0.
      access(1'b1, 7'h7F, 32'h1, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      @(posedge clk_i); #1;
      event_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("inhibit_inc", {62'h0, counter_inc_o}, 64'h2);
      end
      @(posedge clk_i); #1;
      event_i = 2'b00;
      access(1'b0, 7'h7F, 32'h0, 32'h1, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'd0, 32'h0, 32'h5, 1'b0, 2'b00, 2'b00, 2'b00, 0);

      // Backpressure after a write.
      access(1'b1, 7'd0, 32'h1234, 32'h0, 1'b0, 2'b01, 2'b00, 2'b00, 0);
      access(1'b0, 7'd0, 32'h0, 32'h1234, 1'b0, 2'b00, 2'b00, 2'b00, 5);

      // Error addresses leave inhibit and snapshots untouched.
      access(1'b1, 7'd4, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'd4, 32'h0, 32'h0, 1'b1, 2'b00, 2'b00, 2'b00, 0);
      access(1'b1, 7'h7E, 32'hFFFF_FFFF, 32'h0, 1'b1, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'h7F, 32'h0, 32'h1, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);

      // Reset during a stalled high-half write response.
      @(posedge clk_i); #1;
      rready_i = 1'b0;
      req_i    = 1'b1;
      we_i     = 1'b1;
      addr_i   = 7'd3;
      wdata_i  = 32'hABCD;
      @(negedge clk_i);
      check("rst_op_grant", {63'h0, gnt_o}, 64'h1);
      @(posedge clk_i); #1;
      req_i = 1'b0;
      @(negedge clk_i);
      check("rst_op_strobe", {62'h0, counterh_we_o}, 64'h2);
      check("rst_op_rvalid", {63'h0, rvalid_o}, 64'h1);
      rst_ni  = 1'b0;
      event_i = 2'b11;
      #1;
      check("rst_op_rvalid_drop", {63'h0, rvalid_o}, 64'h0);
      check("rst_op_strobe_drop", {60'h0, counter_we_o, counterh_we_o}, 64'h0);
      check("rst_op_inhibit_clear", {62'h0, counter_inc_o}, 64'h3);
      @(negedge clk_i);
      event_i  = 2'b00;
      rready_i = 1'b1;
      rst_ni   = 1'b1;
      #1;
      check("rst_op_gnt", {63'h0, gnt_o}, 64'h1);
      access(1'b0, 7'd3, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      access(1'b0, 7'h7F, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 2'b00, 0);
      access(1'b1, 7'd2, 32'h77, 32'h0, 1'b0, 2'b10, 2'b00, 2'b00, 0);
      access(1'b0, 7'd2, 32'h0, 32'h77, 1'b0, 2'b00, 2'b00, 2'b00, 0);

      repeat (3) @(negedge clk_i);
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/counter_csr_access.md
# counter_csr_access

CSR-side access controller for a bank of `ibex_counter` instances: it is the initiator that drives their write/increment inputs and the reader of their 64-bit values. A 32-bit request/response port handles low/high reads and writes, and a coherent 64-bit read works by snapshotting the high half whenever the low half is read. A per-counter inhibit mask gates event increments. The block sits between the CSR file and the generate-scope counter array.

## Interface
Parameters:
- `NumCounters`, 2, number of attached counters; legal range 1..31.

Ports (all sizes in bits):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted when `req_i && gnt_o`.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  7  register address:
  - `2k` = counter k low half.
  - `2k+1` = counter k high half.
  - `0x7F` = inhibit mask.
  - Any other address is an error.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid.
- `rready_i`  in  1  response accepted when `rvalid_o && rready_i`.
- `rdata_o`  out  32  read data.
- `err_o`  out  1  error flag, qualified by `rvalid_o`.
- `event_i`  in  NumCounters  raw increment events.
- `counter_inc_o`  out  NumCounters  gated increments to the counters.
- `counter_we_o`  out  NumCounters  low-half write strobe.
- `counterh_we_o`  out  NumCounters  high-half write strobe.
- `counter_wdata_o`  out  32  shared write data to the counters.
- `counter_val_i`  in  NumCounters×64  counter values.

## Operation
- FSM states: IDLE, RESP.
  - `gnt_o = (state == IDLE)`.
  - On accept: latch `we`, `addr`, `wdata`, and go to RESP.
  - RESP holds until `rready_i`, then returns to IDLE.
- Write accepted at cycle T:
  - Exactly one strobe (`counter_we_o[k]` or `counterh_we_o[k]`) is high only in cycle T+1, registered, even if RESP is stalled.
  - `counter_wdata_o` = latched wdata.
  - A high-half write also loads `snap_hi[k]` with wdata.
  - An inhibit write sets `inhibit <= wdata[NumCounters-1:0]`, effective from T+1.
- Read of low half of k accepted at T:
  - At the T edge, `rdata <= counter_val_i[k][31:0]` and `snap_hi[k] <= counter_val_i[k][63:32]`.
- Read of high half of k returns `snap_hi[k]`, never the live value.
- Read of inhibit returns the mask zero-extended to 32 bits.
- Error address: `err_o=1`, `rdata_o=0`, no strobe, no state change. Writes to error addresses are ignored.
- Write responses: `rdata_o=0`, `err_o=0`.
- `counter_inc_o = event_i & ~inhibit`. This path is combinational. The counter itself gives write priority over increment.

## Timing
- Reset values:
  - state IDLE, so `gnt_o=1` once reset is released (0 is never required during reset).
  - `rvalid_o=0`, `rdata_o=0`, `err_o=0`.
  - All strobes 0, `counter_wdata_o=0`.
  - `inhibit=0`, all `snap_hi=0`.
- Latency: accept at T, then `rvalid_o` in T+1. `rdata_o`/`err_o` stay stable while `rvalid_o && !rready_i`.
- Throughput is at most one request per 2 cycles. The next accept is no earlier than T+2, so a read after a write observes the written value: the counter registers at the end of T+1.
- `req_i` while in RESP is ignored. The requester holds it.
- Reset mid-RESP drops the response. The strobe is cleared asynchronously.
- Snapshot is per counter: interleaved accesses to other counters do not disturb `snap_hi[k]`.

## Test plan
- Write `0x0000_0005` to addr 0, then read addr 0:
  - `counter_we_o[0]` pulses for exactly 1 cycle.
  - Read returns 5.
  - `rvalid_o` one cycle after each grant.
- Coherent read:
  - Preload counter 1 with `0x0000_0000_FFFF_FFFF` (full-width model).
  - Hold `event_i[1]=1`, read addr 2, then addr 3.
  - Required: low = `0xFFFF_FFFF`, high = `0x0000_0000` (snapshot), even though the live high half has since become 1.
- Inhibit:
  - Write `0x1` to `0x7F`, hold `event_i=2'b11` for 4 cycles.
  - `counter_inc_o=2'b10` throughout.
  - Reading `0x7F` returns 1.
- Backpressure: read with `rready_i=0` for 5 cycles.
  - `rvalid_o` and `rdata_o` are stable.
  - `gnt_o=0`.
  - The write strobe of a preceding write was still a single cycle.
- Error: access to addr 4 with `NumCounters=2` and `we_i=1`.
  - Response `err_o=1`, `rdata_o=0`.
  - No strobe; inhibit and snapshots unchanged.
- Reset mid-operation: assert `rst_ni=0` during a stalled RESP after a high-half write.
  - `rvalid_o` and strobes drop immediately; `snap_hi` and `inhibit` are 0.
  - After release, `gnt_o=1` and a fresh read works.
